// File: rtl/operand_fetch_pkg.sv
// Shared types and widths for the operand-fetch/issue stage.
package operand_fetch_pkg;

  localparam int DATA_W   = 32;
  localparam int IDX_W    = 4;
  localparam int OP_W     = 8;
  localparam int NUM_REGS = 16;

  typedef logic [IDX_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [OP_W-1:0]   op_t;

  typedef struct packed {
    op_t      op;
    word_t    a;
    word_t    b;
    word_t    c;
    reg_idx_t dst;
    logic     wr;
  } issue_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard with set-wins update and per-source/dst hazard outputs.
// With OPERAND_FETCH_BYPASS_EN defined, a register cleared this cycle is not a hazard.
module operand_fetch_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_async_n,
  input  logic       i_set_en,
  input  reg_idx_t   i_set_idx,
  input  logic       i_clr_en,
  input  reg_idx_t   i_clr_idx,
  input  reg_idx_t   i_src_a,
  input  reg_idx_t   i_src_b,
  input  reg_idx_t   i_src_c,
  input  logic [2:0] i_use,
  input  reg_idx_t   i_dst,
  input  logic       i_wr,
  output logic [2:0] o_haz_src,
  output logic       o_haz_dst
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic [NUM_REGS-1:0] w_clr_now;
  logic [NUM_REGS-1:0] w_busy;

`ifdef OPERAND_FETCH_BYPASS_EN
  assign w_clr_now = i_clr_en ? (NUM_REGS'(1) << i_clr_idx) : '0;
`else
  assign w_clr_now = '0;
`endif

  assign w_busy = r_pending & ~w_clr_now;

  assign o_haz_src[0] = i_use[0] && (i_src_a != '0) && w_busy[i_src_a];
  assign o_haz_src[1] = i_use[1] && (i_src_b != '0) && w_busy[i_src_b];
  assign o_haz_src[2] = i_use[2] && (i_src_c != '0) && w_busy[i_src_c];
  assign o_haz_dst    = i_wr && (i_dst != '0) && w_busy[i_dst];

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_comb begin
    w_pend_nxt = r_pending;
    if (i_clr_en) w_pend_nxt[i_clr_idx] = 1'b0;
    if (i_set_en) w_pend_nxt[i_set_idx] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) r_pending <= '0;
    else              r_pending <= w_pend_nxt;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch/issue stage: decode handshake, operand mux, issue register, writeback routing.
// Optional OPERAND_FETCH_BYPASS_EN forwards wb_data to sources in the writeback cycle.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_async_n,
  input  logic       dec_valid,
  output logic       dec_ready,
  input  op_t        dec_op,
  input  reg_idx_t   dec_src_a,
  input  reg_idx_t   dec_src_b,
  input  reg_idx_t   dec_src_c,
  input  logic [2:0] dec_use,
  input  reg_idx_t   dec_dst,
  input  logic       dec_wr,
  output reg_idx_t   rb_read_a_index,
  output reg_idx_t   rb_read_b_index,
  output reg_idx_t   rb_read_c_index,
  input  word_t      rb_read_a,
  input  word_t      rb_read_b,
  input  word_t      rb_read_c,
  output logic       rb_write_en,
  output reg_idx_t   rb_write_index,
  output word_t      rb_write,
  output logic       ex_valid,
  input  logic       ex_ready,
  output op_t        ex_op,
  output word_t      ex_a,
  output word_t      ex_b,
  output word_t      ex_c,
  output reg_idx_t   ex_dst,
  output logic       ex_wr,
  input  logic       wb_valid,
  input  reg_idx_t   wb_index,
  input  word_t      wb_data
);

  issue_t     r_ex;
  issue_t     w_ex_nxt;
  logic       r_ex_valid;
  logic [2:0] w_haz_src;
  logic       w_haz_dst;
  logic       w_accept;

  operand_fetch_scoreboard u_sb (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .i_set_en    (w_accept && dec_wr && (dec_dst != '0)),
    .i_set_idx   (dec_dst),
    .i_clr_en    (wb_valid),
    .i_clr_idx   (wb_index),
    .i_src_a     (dec_src_a),
    .i_src_b     (dec_src_b),
    .i_src_c     (dec_src_c),
    .i_use       (dec_use),
    .i_dst       (dec_dst),
    .i_wr        (dec_wr),
    .o_haz_src   (w_haz_src),
    .o_haz_dst   (w_haz_dst)
  );

  assign dec_ready = (!r_ex_valid || ex_ready) && !(|w_haz_src) && !w_haz_dst;
  assign w_accept  = dec_valid && dec_ready;

  assign rb_read_a_index = dec_src_a;
  assign rb_read_b_index = dec_src_b;
  assign rb_read_c_index = dec_src_c;

  assign rb_write_en    = wb_valid && (wb_index != '0);
  assign rb_write_index = wb_index;
  assign rb_write       = wb_data;

  // Unused sources and r0 read as zero regardless of what the bank returns.
  function automatic word_t operand(input logic used, input reg_idx_t src, input word_t rd);
    word_t v;
    v = (used && (src != '0)) ? rd : '0;
`ifdef OPERAND_FETCH_BYPASS_EN
    if (used && (src != '0) && wb_valid && (wb_index == src)) v = wb_data;
`endif
    return v;
  endfunction

  always_comb begin
    w_ex_nxt     = '0;
    w_ex_nxt.op  = dec_op;
    w_ex_nxt.a   = operand(dec_use[0], dec_src_a, rb_read_a);
    w_ex_nxt.b   = operand(dec_use[1], dec_src_b, rb_read_b);
    w_ex_nxt.c   = operand(dec_use[2], dec_src_c, rb_read_c);
    w_ex_nxt.dst = dec_dst;
    w_ex_nxt.wr  = dec_wr;
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_ex_valid <= 1'b0;
      r_ex       <= '0;
    end else if (w_accept) begin
      r_ex_valid <= 1'b1;
      r_ex       <= w_ex_nxt;
    end else if (ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_op    = r_ex.op;
  assign ex_a     = r_ex.a;
  assign ex_b     = r_ex.b;
  assign ex_c     = r_ex.c;
  assign ex_dst   = r_ex.dst;
  assign ex_wr    = r_ex.wr;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural scoreboard/bank model.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_async_n = 1'b0;
  logic        dec_valid = 1'b0;
  logic        dec_ready;
  logic [7:0]  dec_op = '0;
  logic [3:0]  dec_src_a = '0, dec_src_b = '0, dec_src_c = '0;
  logic [2:0]  dec_use = '0;
  logic [3:0]  dec_dst = '0;
  logic        dec_wr = 1'b0;
  logic [3:0]  rb_read_a_index, rb_read_b_index, rb_read_c_index;
  logic [31:0] rb_read_a, rb_read_b, rb_read_c;
  logic        rb_write_en;
  logic [3:0]  rb_write_index;
  logic [31:0] rb_write;
  logic        ex_valid;
  logic        ex_ready = 1'b1;
  logic [7:0]  ex_op;
  logic [31:0] ex_a, ex_b, ex_c;
  logic [3:0]  ex_dst;
  logic        ex_wr;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_index = '0;
  logic [31:0] wb_data = '0;

  int checks = 0;
  int errors = 0;

  operand_fetch dut (
    .clk(clk), .rst_async_n(rst_async_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
    .dec_src_a(dec_src_a), .dec_src_b(dec_src_b), .dec_src_c(dec_src_c),
    .dec_use(dec_use), .dec_dst(dec_dst), .dec_wr(dec_wr),
    .rb_read_a_index(rb_read_a_index), .rb_read_b_index(rb_read_b_index),
    .rb_read_c_index(rb_read_c_index),
    .rb_read_a(rb_read_a), .rb_read_b(rb_read_b), .rb_read_c(rb_read_c),
    .rb_write_en(rb_write_en), .rb_write_index(rb_write_index), .rb_write(rb_write),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_a(ex_a), .ex_b(ex_b), .ex_c(ex_c), .ex_dst(ex_dst), .ex_wr(ex_wr),
    .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Environment register bank driven by the DUT's write port.
  logic [31:0] bank [16];
  initial for (int i = 0; i < 16; i++) bank[i] = '0;
  assign rb_read_a = bank[rb_read_a_index];
  assign rb_read_b = bank[rb_read_b_index];
  assign rb_read_c = bank[rb_read_c_index];
  always @(posedge clk) if (rb_write_en) bank[rb_write_index] <= rb_write;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending set, own copy of the bank, and the issued instruction.
  bit          m_pend [16];
  logic [31:0] m_bank [16];
  bit          m_v;
  logic [7:0]  m_op;
  logic [31:0] m_a, m_b, m_c;
  logic [3:0]  m_dst;
  bit          m_wr;

  initial for (int i = 0; i < 16; i++) m_bank[i] = '0;

  function automatic bit m_blocked(input logic [3:0] r);
    return (r != 0) && m_pend[r] && !(BYP && wb_valid && wb_index == r);
  endfunction

  function automatic bit m_ready();
    bit h = 1'b0;
    if (dec_use[0] && m_blocked(dec_src_a)) h = 1'b1;
    if (dec_use[1] && m_blocked(dec_src_b)) h = 1'b1;
    if (dec_use[2] && m_blocked(dec_src_c)) h = 1'b1;
    if (dec_wr && m_blocked(dec_dst))       h = 1'b1;
    return (!m_v || ex_ready) && !h;
  endfunction

  function automatic logic [31:0] m_opnd(input bit used, input logic [3:0] r);
    if (!used || r == 0) return 32'h0;
    if (BYP && wb_valid && wb_index == r) return wb_data;
    return m_bank[r];
  endfunction

  always @(posedge clk or negedge rst_async_n) begin
    bit acc;
    logic [31:0] na, nb, nc;
    if (!rst_async_n) begin
      for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
      m_v = 0; m_op = '0; m_a = '0; m_b = '0; m_c = '0; m_dst = '0; m_wr = 0;
    end else begin
      acc = dec_valid && m_ready();
      na = m_opnd(dec_use[0], dec_src_a);
      nb = m_opnd(dec_use[1], dec_src_b);
      nc = m_opnd(dec_use[2], dec_src_c);
      if (wb_valid) m_pend[wb_index] = 1'b0;
      if (wb_valid && wb_index != 0) m_bank[wb_index] = wb_data;
      if (acc) begin
        m_v = 1; m_op = dec_op; m_a = na; m_b = nb; m_c = nc; m_dst = dec_dst; m_wr = dec_wr;
        if (dec_wr && dec_dst != 0) m_pend[dec_dst] = 1'b1;
      end else if (ex_ready) begin
        m_v = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("ex_valid", 32'(ex_valid), 32'(m_v));
    chk("ex_op", 32'(ex_op), 32'(m_op));
    chk("ex_a", ex_a, m_a);
    chk("ex_b", ex_b, m_b);
    chk("ex_c", ex_c, m_c);
    chk("ex_dst", 32'(ex_dst), 32'(m_dst));
    chk("ex_wr", 32'(ex_wr), 32'(m_wr));
    chk("dec_ready", 32'(dec_ready), 32'(m_ready()));
    chk("rb_read_idx", {20'h0, rb_read_c_index, rb_read_b_index, rb_read_a_index},
        {20'h0, dec_src_c, dec_src_b, dec_src_a});
    chk("rb_write_en", 32'(rb_write_en), 32'(wb_valid && wb_index != 0));
    chk("rb_write_index", 32'(rb_write_index), 32'(wb_index));
    chk("rb_write", rb_write, wb_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [7:0] op, input logic [2:0] u,
                         input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] sc,
                         input logic w, input logic [3:0] d);
    dec_valid = v; dec_op = op; dec_use = u;
    dec_src_a = sa; dec_src_b = sb; dec_src_c = sc; dec_wr = w; dec_dst = d;
  endtask

  initial begin
    #1; chk("reset_dec_ready", 32'(dec_ready), 32'h1);
    chk("reset_ex_valid", 32'(ex_valid), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_async_n = 1'b1;
    step();

    // First issue from a zeroed bank.
    ex_ready = 1;
    set_dec(1, 8'h11, 3'b011, 4'd1, 4'd2, 4'd0, 0, 4'd0);
    #1 chk("t1_ready", 32'(dec_ready), 32'h1);
    step();
    chk("t1_ex_valid", 32'(ex_valid), 32'h1);
    chk("t1_ex_op", 32'(ex_op), 32'h11);
    chk("t1_ex_a", ex_a, 32'h0);
    chk("t1_ex_b", ex_b, 32'h0);

    // RAW on r3 resolved by writeback.
    set_dec(1, 8'h03, 3'b000, 4'd0, 4'd0, 4'd0, 1, 4'd3);
    step();
    set_dec(1, 8'h04, 3'b001, 4'd3, 4'd0, 4'd0, 0, 4'd0);
    #1 chk("raw_stall", 32'(dec_ready), 32'h0);
    step();
    chk("raw_stall_exv", 32'(ex_valid), 32'h0);
    wb_valid = 1; wb_index = 4'd3; wb_data = 32'hDEADBEEF;
`ifdef OPERAND_FETCH_BYPASS_EN
    #1 chk("raw_wb_ready", 32'(dec_ready), 32'h1);
    step();
    wb_valid = 0;
`else
    #1 chk("raw_wb_ready", 32'(dec_ready), 32'h0);
    step();
    wb_valid = 0;
    #1 chk("raw_after_wb_ready", 32'(dec_ready), 32'h1);
    step();
`endif
    chk("raw_ex_op", 32'(ex_op), 32'h04);
    chk("raw_ex_a", ex_a, 32'hDEADBEEF);
    dec_valid = 0;
    step();

    // Execute back-pressure holds the issued instruction.
    set_dec(1, 8'h22, 3'b000, 4'd0, 4'd0, 4'd0, 0, 4'd0);
    ex_ready = 0;
    step();
    dec_op = 8'h33;
    repeat (3) begin
      #1 chk("bp_ready", 32'(dec_ready), 32'h0);
      step();
      chk("bp_ex_op", 32'(ex_op), 32'h22);
      chk("bp_ex_valid", 32'(ex_valid), 32'h1);
    end
    ex_ready = 1;
    #1 chk("bp_release_ready", 32'(dec_ready), 32'h1);
    step();
    chk("bp_next_op", 32'(ex_op), 32'h33);

    // WAW on r5.
    set_dec(1, 8'h50, 3'b000, 4'd0, 4'd0, 4'd0, 1, 4'd5);
    step();
    dec_op = 8'h55;
    #1 chk("waw_stall", 32'(dec_ready), 32'h0);
    step();
    wb_valid = 1; wb_index = 4'd5; wb_data = 32'h5555;
`ifdef OPERAND_FETCH_BYPASS_EN
    #1 chk("waw_wb_ready", 32'(dec_ready), 32'h1);
    step();
    wb_valid = 0;
`else
    #1 chk("waw_wb_ready", 32'(dec_ready), 32'h0);
    step();
    wb_valid = 0;
    #1 chk("waw_after_ready", 32'(dec_ready), 32'h1);
    step();
`endif
    chk("waw_ex_op", 32'(ex_op), 32'h55);
    set_dec(1, 8'h56, 3'b001, 4'd5, 4'd0, 4'd0, 0, 4'd0);
    #1 chk("waw_r5_still_pending", 32'(dec_ready), 32'h0);
    dec_valid = 0; wb_valid = 1; wb_index = 4'd5;
    step();
    wb_valid = 0;

    // r0 is never written, never pending, always reads zero.
    set_dec(1, 8'h60, 3'b000, 4'd0, 4'd0, 4'd0, 1, 4'd0);
    wb_valid = 1; wb_index = 4'd0; wb_data = 32'h1234;
    #1 chk("r0_wr_en", 32'(rb_write_en), 32'h0);
    chk("r0_ready", 32'(dec_ready), 32'h1);
    step();
    wb_valid = 0;
    set_dec(1, 8'h61, 3'b001, 4'd0, 4'd0, 4'd0, 0, 4'd0);
    #1 chk("r0_read_ready", 32'(dec_ready), 32'h1);
    step();
    chk("r0_ex_a", ex_a, 32'h0);
    chk("r0_ex_op", 32'(ex_op), 32'h61);

    // Asynchronous reset mid-operation.
    set_dec(1, 8'h70, 3'b000, 4'd0, 4'd0, 4'd0, 1, 4'd7);
    step();
    dec_valid = 0; ex_ready = 0;
    #1 chk("rst_pre_valid", 32'(ex_valid), 32'h1);
    rst_async_n = 0;
    #1 chk("rst_ex_valid", 32'(ex_valid), 32'h0);
    chk("rst_ex_op", 32'(ex_op), 32'h0);
    set_dec(1, 8'h71, 3'b001, 4'd7, 4'd0, 4'd0, 0, 4'd0);
    #1 chk("rst_pend_clear", 32'(dec_ready), 32'h1);
    @(negedge clk);
    #1 rst_async_n = 1; dec_valid = 0; ex_ready = 1;
    step();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      set_dec(($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom),
              4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
              1'($urandom), 4'($urandom_range(0, 7)));
      ex_ready = ($urandom_range(0, 3) != 0);
      wb_valid = ($urandom_range(0, 4) < 2);
      wb_index = 4'($urandom_range(0, 7));
      wb_data  = $urandom;
      step();
    end
    dec_valid = 0; wb_valid = 0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
